// File: rtl/spi_pwm_bank.sv
// spi_pwm_bank: bit-serial command port writing duty values into a bank of
// double-buffered PWM channels sharing one prescaled counter.
// Frames are enable-framed, LSB first: {address, duty}. Address 0 broadcasts.
// Optional build macro SPI_PWM_BLANK_EN forces pwm_out low while enable is high.
module spi_pwm_bank #(
    parameter int CHANNELS   = 3,
    parameter int PWM_WIDTH  = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int PRESCALE   = 1,
    parameter int RESET_DUTY = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                data,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                frame_valid,
    output logic                frame_err
);

    localparam int FRAME_BITS = ADDR_WIDTH + PWM_WIDTH;
    // bit_cnt must reach FRAME_BITS+1 so over-long frames stay distinguishable
    localparam int BC_W       = $clog2(FRAME_BITS + 2);
    localparam logic [BC_W-1:0] BC_FULL = BC_W'(FRAME_BITS);
    localparam logic [BC_W-1:0] BC_SAT  = BC_W'(FRAME_BITS + 1);
    localparam int PS_W       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [PWM_WIDTH-1:0] CNT_MAX  = {PWM_WIDTH{1'b1}};
    localparam logic [PWM_WIDTH-1:0] DUTY_RST = PWM_WIDTH'(RESET_DUTY);

    logic [BC_W-1:0]       bit_cnt_reg;
    logic [FRAME_BITS-1:0] shift_reg;
    logic                  enable_prev_reg;
    logic                  frame_valid_reg;
    logic                  frame_err_reg;
    logic [PS_W-1:0]       prescale_reg;
    logic [PWM_WIDTH-1:0]  cnt_reg;

    logic                  commit;
    logic                  frame_ok;
    logic                  write_en;
    logic                  step;
    logic                  wrap;
    logic [ADDR_WIDTH-1:0] frame_addr;
    logic [PWM_WIDTH-1:0]  frame_duty;

    // Commit fires on the first low enable sample after a high one
    assign commit     = !enable && enable_prev_reg;
    assign frame_ok   = (bit_cnt_reg == BC_FULL);
    assign write_en   = commit && frame_ok;
    assign frame_addr = shift_reg[FRAME_BITS-1:PWM_WIDTH];
    assign frame_duty = shift_reg[PWM_WIDTH-1:0];
    assign step       = (prescale_reg == PS_LAST);
    assign wrap       = step && (cnt_reg == CNT_MAX);

    // Serial receiver: place each bit at bit_cnt, saturate the count, clear on commit
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_reg     <= '0;
            shift_reg       <= '0;
            enable_prev_reg <= 1'b0;
        end else begin
            enable_prev_reg <= enable;
            if (enable) begin
                for (int b = 0; b < FRAME_BITS; b++) begin
                    if (bit_cnt_reg == BC_W'(b)) begin
                        shift_reg[b] <= data;
                    end
                end
                if (bit_cnt_reg != BC_SAT) begin
                    bit_cnt_reg <= bit_cnt_reg + BC_W'(1);
                end
            end else if (commit) begin
                bit_cnt_reg <= '0;
            end
        end
    end

    // Frame status pulses, one cycle each, on the commit edge
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_valid_reg <= 1'b0;
            frame_err_reg   <= 1'b0;
        end else begin
            frame_valid_reg <= commit && frame_ok;
            frame_err_reg   <= commit && !frame_ok;
        end
    end

    assign frame_valid = frame_valid_reg;
    assign frame_err   = frame_err_reg;

    // Shared PWM counter, advanced once every PRESCALE clocks, wrapping naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            prescale_reg <= '0;
            cnt_reg      <= '0;
        end else if (step) begin
            prescale_reg <= '0;
            cnt_reg      <= cnt_reg + PWM_WIDTH'(1);
        end else begin
            prescale_reg <= prescale_reg + PS_W'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [PWM_WIDTH-1:0] shadow_reg;
            logic [PWM_WIDTH-1:0] active_reg;
            logic                 pwm_reg;
            logic                 hit;

            assign hit = write_en &&
                         ((frame_addr == '0) || (frame_addr == ADDR_WIDTH'(gi + 1)));

            // Shadow takes commits; active copies shadow only at the period wrap,
            // so a commit on the wrap edge lands one period later
            always_ff @(posedge clk) begin
                if (rst) begin
                    shadow_reg <= DUTY_RST;
                    active_reg <= DUTY_RST;
                    pwm_reg    <= 1'b0;
                end else begin
                    if (wrap) begin
                        active_reg <= shadow_reg;
                    end
                    if (hit) begin
                        shadow_reg <= frame_duty;
                    end
`ifdef SPI_PWM_BLANK_EN
                    pwm_reg <= !enable && (cnt_reg < active_reg);
`else
                    pwm_reg <= (cnt_reg < active_reg);
`endif
                end
            end

            assign pwm_out[gi] = pwm_reg;
        end
    endgenerate

endmodule

// File: tb/tb_spi_pwm_bank.sv
// Self-checking bench for spi_pwm_bank: a cycle-level behavioural model
// (counter phase derived arithmetically from cycles since reset, frames
// collected in a queue) checked every cycle, plus literal duty-count checks.
module tb_spi_pwm_bank;

    localparam int CH     = 3;
    localparam int PW     = 8;
    localparam int AW     = 8;
    localparam int PS     = 4;
    localparam int RD     = 128;
    localparam int FB     = AW + PW;
    localparam int PERIOD = PS * (1 << PW);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          data = 1'b0;
    logic [CH-1:0] pwm_out;
    logic          frame_valid;
    logic          frame_err;

    int checks = 0;
    int errors = 0;
    bit chk_on = 0;

    always #5 clk = ~clk;

    spi_pwm_bank #(
        .CHANNELS(CH), .PWM_WIDTH(PW), .ADDR_WIDTH(AW),
        .PRESCALE(PS), .RESET_DUTY(RD)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .data(data),
        .pwm_out(pwm_out), .frame_valid(frame_valid), .frame_err(frame_err)
    );

    // ---------------- behavioural model ----------------
    int unsigned   m_n;           // non-reset edges since reset
    int            m_shadow [CH];
    int            m_active [CH];
    logic [CH-1:0] exp_pwm;
    logic          exp_valid;
    logic          exp_err;
    bit            m_bits [$];
    bit            m_open;
    int            m_c, m_word, m_addr, m_duty;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_n = 0;
                for (int i = 0; i < CH; i++) begin
                    m_shadow[i] = RD;
                    m_active[i] = RD;
                end
                exp_pwm   = '0;
                exp_valid = 1'b0;
                exp_err   = 1'b0;
                m_bits.delete();
                m_open = 0;
            end else begin
                m_c = int'((m_n / PS) % (1 << PW));
                for (int i = 0; i < CH; i++) exp_pwm[i] = (m_c < m_active[i]);
`ifdef SPI_PWM_BLANK_EN
                if (enable) exp_pwm = '0;
`endif
                if (((m_n + 1) % PERIOD) == 0)
                    for (int i = 0; i < CH; i++) m_active[i] = m_shadow[i];
                exp_valid = 1'b0;
                exp_err   = 1'b0;
                if (enable) begin
                    m_bits.push_back(data);
                    m_open = 1;
                end else if (m_open) begin
                    if (m_bits.size() == FB) begin
                        m_word = 0;
                        for (int k = 0; k < FB; k++) m_word = m_word | (int'(m_bits[k]) << k);
                        m_addr = m_word >> PW;
                        m_duty = m_word % (1 << PW);
                        if (m_addr == 0) begin
                            for (int i = 0; i < CH; i++) m_shadow[i] = m_duty;
                        end else if (m_addr <= CH) begin
                            m_shadow[m_addr-1] = m_duty;
                        end
                        exp_valid = 1'b1;
                    end else begin
                        exp_err = 1'b1;
                    end
                    m_bits.delete();
                    m_open = 0;
                end
                m_n++;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Per-cycle compare against the model
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                chk("pwm_out", 32'(pwm_out), 32'(exp_pwm));
                chk("frame_valid", 32'(frame_valid), 32'(exp_valid));
                chk("frame_err", 32'(frame_err), 32'(exp_err));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    int cnt_hi [CH];

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input int len, input int word, input bit lit, input bit exp_v,
                        input string name);
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            enable = 1'b1;
            data   = ((word >> k) & 1) != 0;
        end
        @(negedge clk);
        enable = 1'b0;
        data   = 1'b0;
        $display("frame %s: %0d bits word=%05h", name, len, word);
        if (lit) begin
            @(negedge clk);
            chk({name, "_valid"}, 32'(frame_valid), 32'(exp_v));
            chk({name, "_err"}, 32'(frame_err), 32'(!exp_v));
        end
    endtask

    // Count high samples over PERIOD cycles starting at the current negedge
    task automatic count_now();
        for (int i = 0; i < CH; i++) cnt_hi[i] = 0;
        for (int j = 0; j < PERIOD; j++) begin
            for (int i = 0; i < CH; i++) cnt_hi[i] += int'(pwm_out[i]);
            @(negedge clk);
        end
    endtask

    // Count over one full PWM period aligned just after a wrap
    task automatic count_period();
        tick(2);
        while ((m_n % PERIOD) != 1) @(negedge clk);
        count_now();
    endtask

    task automatic chk_counts(input string name, input int c0, input int c1, input int c2);
        chk({name, "_ch0"}, 32'(cnt_hi[0]), 32'(c0));
        chk({name, "_ch1"}, 32'(cnt_hi[1]), 32'(c1));
        chk({name, "_ch2"}, 32'(cnt_hi[2]), 32'(c2));
    endtask

    int lens [4] = '{15, 17, 1, 20};

    initial begin
        int len, addr, duty, idle;
        rst = 1'b1;
        tick(3);
        chk_on = 1;
        chk("reset_pwm", 32'(pwm_out), 32'h0);
        rst = 1'b0;

        // Reset duty 0x80: 128 of 256 steps, 4 clk per step
        count_period();
        chk_counts("reset_duty", 512, 512, 512);

        send(16, 'h0240, 1, 1, "addr2");
        count_period();
        chk_counts("addr2", 512, 256, 512);

        send(16, 'h00FF, 1, 1, "bcast");
        count_period();
        chk_counts("bcast", 1020, 1020, 1020);

        send(16, 'h0100, 1, 1, "ch0off");
        count_period();
        chk_counts("ch0off", 0, 1020, 1020);

        send(15, 'h0133, 1, 0, "short15");
        send(17, 'h10133, 1, 0, "long17");
        send(16, 'h0733, 1, 1, "addr7");
        count_period();
        chk_counts("nochange", 0, 1020, 1020);

        send(16, 'h0301, 1, 1, "ch2duty1");
        count_period();
        chk_counts("ch2duty1", 0, 1020, 4);

        // Commit landing exactly on the wrap edge
        while (((m_n + 18) % PERIOD) != 0) @(negedge clk);
        send(16, 'h0110, 1, 1, "wrapcommit");
        count_now();
        chk("wrap_old_period", 32'(cnt_hi[0]), 32'd0);
        count_now();
        chk("wrap_new_period", 32'(cnt_hi[0]), 32'd64);

        // Reset in the middle of a frame, enable held high across release
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            enable = 1'b1;
            data   = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        data = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 0) rst = 1'b0;
            data = ((('h0233) >> k) & 1) != 0;
        end
        @(negedge clk);
        enable = 1'b0;
        data   = 1'b0;
        $display("frame rstmid: 16 bits word=00233 after mid-frame reset");
        @(negedge clk);
        chk("rstmid_valid", 32'(frame_valid), 32'd1);
        count_period();
        chk_counts("rstmid", 512, 204, 512);

        // Randomized frames, lengths, gaps and idle data
        for (int f = 0; f < 40; f++) begin
            len  = ($urandom_range(0, 9) < 7) ? FB : lens[$urandom_range(0, 3)];
            addr = $urandom_range(0, CH + 2);
            duty = $urandom_range(0, 255);
            send(len, (addr << PW) | duty | (($urandom_range(0, 1)) << FB), 0, 0, "rand");
            idle = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1500) : $urandom_range(0, 2);
            for (int k = 0; k < idle; k++) begin
                @(negedge clk);
                data = 1'($urandom_range(0, 1));
            end
        end
        tick(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
